// File: rtl/kfpga_io_pkg.sv
// Field-width and field-offset helpers shared by the IO tile RTL and the bitstream checker.
// No latency or flow control; pure compile-time arithmetic.
package kfpga_io_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int io_field_width(input int ic_width);
    return sel_width(ic_width) + 2;
  endfunction

  function automatic int ic_field_width(input int io_count);
    return sel_width(io_count) + 1;
  endfunction

  function automatic int cfg_bits(input int io_count, input int ic_width);
    return io_count * io_field_width(ic_width) + ic_width * ic_field_width(io_count);
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Pad fields occupy the low end of the word, interconnect fields follow.
  function automatic int io_field_offset(input int i, input int ic_width);
    return i * io_field_width(ic_width);
  endfunction

  function automatic int ic_field_offset(input int j, input int io_count, input int ic_width);
    return io_count * io_field_width(ic_width) + j * ic_field_width(io_count);
  endfunction

endpackage

// File: rtl/io_config_chain.sv
// Serial config shift chain with shadow (active) register, atomic commit and load counter.
// Latency: config_in reaches config_out after WIDTH shifts; no backpressure, caller paces via config_enable.
module io_config_chain
  import kfpga_io_pkg::*;
#(
  parameter int WIDTH = 38
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             config_in,
  input  logic             config_enable,
  input  logic             config_commit,
  output logic             config_out,
  output logic             config_loaded,
  output logic [WIDTH-1:0] active
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] chain;
  logic [CNT_W-1:0] cnt;

  // Shifting takes priority: a commit arriving mid-shift is dropped.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      chain  <= '0;
      active <= '0;
      cnt    <= '0;
    end else if (config_enable) begin
      chain <= {chain[WIDTH-2:0], config_in};
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (config_commit) begin
      active <= chain;
      cnt    <= '0;
    end
  end

  assign config_out    = chain[WIDTH-1];
  assign config_loaded = (cnt == CNT_MAX);

endmodule

// File: rtl/param_io_tile_top.sv
// Perimeter IO tile: daisy-chained config plus pad<->interconnect routing with optional per-path flops.
// Latency: 0 or 1 cycle per path (config-selected); no backpressure, flops advance on enable.
module param_io_tile_top
  import kfpga_io_pkg::*;
#(
  parameter int IO_COUNT = 4,
  parameter int IC_WIDTH = 6
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                config_in,
  output logic                config_out,
  input  logic                config_enable,
  input  logic                config_commit,
  output logic                config_loaded,
  input  logic                enable,
  input  logic [IO_COUNT-1:0] data_from_io,
  output logic [IO_COUNT-1:0] data_to_io,
  output logic [IO_COUNT-1:0] data_oe,
  input  logic [IC_WIDTH-1:0] data_from_ic,
  output logic [IC_WIDTH-1:0] data_to_ic
);

  localparam int OSEL_W   = sel_width(IC_WIDTH);
  localparam int ISEL_W   = sel_width(IO_COUNT);
  localparam int IO_FW    = io_field_width(IC_WIDTH);
  localparam int IC_FW    = ic_field_width(IO_COUNT);
  localparam int CFG_BITS = cfg_bits(IO_COUNT, IC_WIDTH);
  localparam int IC_EXT   = 1 << OSEL_W;
  localparam int IO_EXT   = 1 << ISEL_W;

  logic [CFG_BITS-1:0] active;
  // Zero-padding to the full select range makes out-of-range selects read 0.
  logic [IC_EXT-1:0]   ic_ext;
  logic [IO_EXT-1:0]   io_ext;

  assign ic_ext = IC_EXT'(data_from_ic);
  assign io_ext = IO_EXT'(data_from_io);

  io_config_chain #(.WIDTH(CFG_BITS)) u_chain (
    .clock         (clock),
    .nreset        (nreset),
    .config_in     (config_in),
    .config_enable (config_enable),
    .config_commit (config_commit),
    .config_out    (config_out),
    .config_loaded (config_loaded),
    .active        (active)
  );

  for (genvar i = 0; i < IO_COUNT; i++) begin : g_pad
    logic [IO_FW-1:0]  fld;
    logic [OSEL_W-1:0] osel;
    logic              src;
    logic              q;

    assign fld  = active[io_field_offset(i, IC_WIDTH) +: IO_FW];
    assign osel = fld[OSEL_W-1:0];
    assign src  = ic_ext[osel];

    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)     q <= 1'b0;
      else if (enable) q <= src;
    end

    assign data_to_io[i] = fld[OSEL_W] ? q : src;
    assign data_oe[i]    = fld[OSEL_W+1];
  end

  for (genvar j = 0; j < IC_WIDTH; j++) begin : g_ic
    logic [IC_FW-1:0]  fld;
    logic [ISEL_W-1:0] isel;
    logic              src;
    logic              q;

    assign fld  = active[ic_field_offset(j, IO_COUNT, IC_WIDTH) +: IC_FW];
    assign isel = fld[ISEL_W-1:0];
    assign src  = io_ext[isel];

    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)     q <= 1'b0;
      else if (enable) q <= src;
    end

    assign data_to_ic[j] = fld[ISEL_W] ? q : src;
  end

endmodule

// File: tb/tb_param_io_tile_top.sv
// Two daisy-chained IO tiles checked against a queue-based behavioural model.
module tb_param_io_tile_top;

  localparam int IO_COUNT = 4;
  localparam int IC_WIDTH = 6;
  localparam int IO_FW    = 5;
  localparam int IC_FW    = 3;
  localparam int IC_BASE  = IO_COUNT * IO_FW;
  localparam int CFG_BITS = 38;

  logic clock = 1'b0;
  logic nreset, config_in, config_enable, config_commit, enable;
  logic [3:0] data_from_io;
  logic [5:0] data_from_ic;
  logic cfg_out0, cfg_out1, loaded0, loaded1;
  logic [3:0] to_io0, to_io1, oe0, oe1;
  logic [5:0] to_ic0, to_ic1;

  always #5 clock = ~clock;

  param_io_tile_top #(.IO_COUNT(IO_COUNT), .IC_WIDTH(IC_WIDTH)) dut0 (
    .clock(clock), .nreset(nreset), .config_in(config_in), .config_out(cfg_out0),
    .config_enable(config_enable), .config_commit(config_commit), .config_loaded(loaded0),
    .enable(enable), .data_from_io(data_from_io), .data_to_io(to_io0), .data_oe(oe0),
    .data_from_ic(data_from_ic), .data_to_ic(to_ic0));

  param_io_tile_top #(.IO_COUNT(IO_COUNT), .IC_WIDTH(IC_WIDTH)) dut1 (
    .clock(clock), .nreset(nreset), .config_in(cfg_out0), .config_out(cfg_out1),
    .config_enable(config_enable), .config_commit(config_commit), .config_loaded(loaded1),
    .enable(enable), .data_from_io(data_from_io), .data_to_io(to_io1), .data_oe(oe1),
    .data_from_ic(data_from_ic), .data_to_ic(to_ic1));

  // Model: each tile's chain is the last CFG_BITS bits it was fed (oldest first).
  bit          q0[$];
  bit          q1[$];
  int          cnt_m[2];
  logic [37:0] act_m[2];
  logic [3:0]  qio_m[2];
  logic [5:0]  qic_m[2];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0] fio;
    logic [5:0] fic;
    logic       en;
    logic [3:0] exp_io;
    logic [5:0] exp_ic;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [37:0] chain_m(input int t);
    logic [37:0] v = '0;
    int n = (t == 0) ? q0.size() : q1.size();
    for (int k = 0; k < n; k++) v[n-1-k] = (t == 0) ? q0[k] : q1[k];
    return v;
  endfunction

  function automatic logic cout_m(input int t);
    if (t == 0) return (q0.size() == CFG_BITS) ? q0[0] : 1'b0;
    return (q1.size() == CFG_BITS) ? q1[0] : 1'b0;
  endfunction

  function automatic logic pad_src(input logic [37:0] a, input int i);
    logic [2:0] osel = a[i*IO_FW +: 3];
    return (int'(osel) < IC_WIDTH) ? data_from_ic[osel] : 1'b0;
  endfunction

  function automatic logic ic_src(input logic [37:0] a, input int j);
    logic [1:0] isel = a[IC_BASE + j*IC_FW +: 2];
    return (int'(isel) < IO_COUNT) ? data_from_io[isel] : 1'b0;
  endfunction

  function automatic logic [3:0] exp_io(input int t);
    logic [3:0] v;
    for (int i = 0; i < IO_COUNT; i++)
      v[i] = act_m[t][i*IO_FW+3] ? qio_m[t][i] : pad_src(act_m[t], i);
    return v;
  endfunction

  function automatic logic [3:0] exp_oe(input int t);
    logic [3:0] v;
    for (int i = 0; i < IO_COUNT; i++) v[i] = act_m[t][i*IO_FW+4];
    return v;
  endfunction

  function automatic logic [5:0] exp_ic(input int t);
    logic [5:0] v;
    for (int j = 0; j < IC_WIDTH; j++)
      v[j] = act_m[t][IC_BASE+j*IC_FW+2] ? qic_m[t][j] : ic_src(act_m[t], j);
    return v;
  endfunction

  function automatic logic [37:0] set_io(input logic [37:0] c, input int i,
                                         input logic oe, input logic rg, input logic [2:0] osel);
    c[i*IO_FW +: IO_FW] = {oe, rg, osel};
    return c;
  endfunction

  function automatic logic [37:0] set_ic(input logic [37:0] c, input int j,
                                         input logic rg, input logic [1:0] isel);
    c[IC_BASE + j*IC_FW +: IC_FW] = {rg, isel};
    return c;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int t = 0; t < 2; t++) begin
      cnt_m[t] = 0;
      act_m[t] = '0;
      qio_m[t] = '0;
      qic_m[t] = '0;
    end
  endtask

  task automatic check_all();
    chk("to_io0", 8'(to_io0), 8'(exp_io(0)));
    chk("oe0", 8'(oe0), 8'(exp_oe(0)));
    chk("to_ic0", 8'(to_ic0), 8'(exp_ic(0)));
    chk("cfg_out0", 8'(cfg_out0), 8'(cout_m(0)));
    chk("loaded0", 8'(loaded0), 8'(cnt_m[0] == CFG_BITS));
    chk("to_io1", 8'(to_io1), 8'(exp_io(1)));
    chk("oe1", 8'(oe1), 8'(exp_oe(1)));
    chk("to_ic1", 8'(to_ic1), 8'(exp_ic(1)));
    chk("cfg_out1", 8'(cfg_out1), 8'(cout_m(1)));
    chk("loaded1", 8'(loaded1), 8'(cnt_m[1] == CFG_BITS));
  endtask

  // Applies the model's view of one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic c0;
    for (int t = 0; t < 2; t++) begin
      if (enable) begin
        for (int i = 0; i < IO_COUNT; i++) qio_m[t][i] = pad_src(act_m[t], i);
        for (int j = 0; j < IC_WIDTH; j++) qic_m[t][j] = ic_src(act_m[t], j);
      end
    end
    if (config_enable) begin
      c0 = cout_m(0);
      q0.push_back(config_in);
      if (q0.size() > CFG_BITS) void'(q0.pop_front());
      q1.push_back(c0);
      if (q1.size() > CFG_BITS) void'(q1.pop_front());
      for (int t = 0; t < 2; t++) if (cnt_m[t] < CFG_BITS) cnt_m[t]++;
    end else if (config_commit) begin
      for (int t = 0; t < 2; t++) begin
        act_m[t] = chain_m(t);
        cnt_m[t] = 0;
      end
    end
  endtask

  task automatic drive(input logic ce, input logic ci, input logic cc, input logic en,
                       input logic [3:0] fio, input logic [5:0] fic);
    @(negedge clock);
    config_enable = ce;
    config_in     = ci;
    config_commit = cc;
    enable        = en;
    data_from_io  = fio;
    data_from_ic  = fic;
    #1 check_all();
  endtask

  task automatic clk_edge();
    @(posedge clock);
    model_edge();
  endtask

  task automatic cyc(input logic ce, input logic ci, input logic cc, input logic en,
                     input logic [3:0] fio, input logic [5:0] fic);
    drive(ce, ci, cc, en, fio, fic);
    clk_edge();
  endtask

  task automatic load_bits(input logic [37:0] c, input logic [3:0] fio, input logic [5:0] fic);
    for (int k = CFG_BITS - 1; k >= 0; k--) cyc(1'b1, c[k], 1'b0, 1'b1, fio, fic);
  endtask

  task automatic rand_cyc(input logic ce, input logic cc);
    cyc(ce, 1'($urandom_range(0, 1)), cc, 1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom));
  endtask

  logic [37:0] c2, ca, cb, rc;

  initial begin
    tbl[0] = '{4'b1000, 6'b100001, 1'b1, 4'b0001, 6'b000010};
    tbl[1] = '{4'b0001, 6'b000100, 1'b1, 4'b1100, 6'b000101};
    tbl[2] = '{4'b1110, 6'b111111, 1'b0, 4'b1001, 6'b111010};
    tbl[3] = '{4'b0110, 6'b011110, 1'b1, 4'b1000, 6'b111000};
    tbl[4] = '{4'b1001, 6'b100101, 1'b1, 4'b1001, 6'b000011};
    tbl[5] = '{4'b0000, 6'b000000, 1'b0, 4'b0100, 6'b100100};

    c2 = '0;
    c2 = set_io(c2, 0, 1'b1, 1'b0, 3'd5);
    c2 = set_io(c2, 1, 1'b1, 1'b0, 3'd7);
    c2 = set_io(c2, 2, 1'b1, 1'b1, 3'd0);
    c2 = set_io(c2, 3, 1'b0, 1'b0, 3'd2);
    c2 = set_ic(c2, 0, 1'b0, 2'd0);
    c2 = set_ic(c2, 1, 1'b0, 2'd3);
    c2 = set_ic(c2, 2, 1'b1, 2'd3);
    c2 = set_ic(c2, 3, 1'b0, 2'd1);
    c2 = set_ic(c2, 4, 1'b0, 2'd2);
    c2 = set_ic(c2, 5, 1'b1, 2'd0);

    ca = '0;
    ca = set_io(ca, 0, 1'b1, 1'b0, 3'd1);
    ca = set_io(ca, 1, 1'b0, 1'b1, 3'd4);
    ca = set_io(ca, 2, 1'b1, 1'b0, 3'd3);
    ca = set_io(ca, 3, 1'b0, 1'b0, 3'd6);
    ca = set_ic(ca, 0, 1'b0, 2'd2);
    ca = set_ic(ca, 1, 1'b1, 2'd1);
    ca = set_ic(ca, 4, 1'b1, 2'd2);
    ca = set_ic(ca, 5, 1'b0, 2'd1);
    cb = '0;
    cb = set_io(cb, 0, 1'b0, 1'b0, 3'd2);
    cb = set_io(cb, 1, 1'b1, 1'b0, 3'd5);
    cb = set_io(cb, 2, 1'b0, 1'b1, 3'd1);
    cb = set_io(cb, 3, 1'b1, 1'b0, 3'd0);
    cb = set_ic(cb, 0, 1'b0, 2'd1);
    cb = set_ic(cb, 2, 1'b1, 2'd3);
    cb = set_ic(cb, 3, 1'b0, 2'd2);
    cb = set_ic(cb, 4, 1'b0, 2'd3);
    cb = set_ic(cb, 5, 1'b1, 2'd0);

    nreset = 1'b0; config_in = 1'b0; config_enable = 1'b0; config_commit = 1'b0;
    enable = 1'b0; data_from_io = '0; data_from_ic = '0;
    reset_model();
    #1 check_all();
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;

    // Load and commit a single-tile config; loaded flag rises on the last shift.
    load_bits(c2, 4'b0000, 6'b000000);
    #2 chk("loaded_at_38", 8'(loaded0), 8'd1);
    chk("oe_before_commit", 8'(oe0), 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 6'b100000);
    #2 chk("oe_after_commit", 8'(oe0), 8'b0111);
    chk("pad0_follows_ic5", 8'(to_io0[0]), 8'd1);
    chk("loaded_cleared", 8'(loaded0), 8'd0);

    // Fixed vectors: clamp, combinational and registered paths, enable hold.
    for (int v = 0; v < 6; v++) begin
      drive(1'b0, 1'b0, 1'b0, tbl[v].en, tbl[v].fio, tbl[v].fic);
      chk($sformatf("tbl%0d_to_io", v), 8'(to_io0), 8'(tbl[v].exp_io));
      chk($sformatf("tbl%0d_to_ic", v), 8'(to_ic0), 8'(tbl[v].exp_ic));
      chk($sformatf("tbl%0d_oe", v), 8'(oe0), 8'b0111);
      clk_edge();
    end

    // Commit while shifting is dropped.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 6'b010101);
    #2 chk("commit_in_shift_oe", 8'(oe0), 8'b0111);
    chk("commit_in_shift_loaded", 8'(loaded0), 8'd0);

    // Two tiles: the far tile's config goes in first.
    load_bits(cb, 4'b0100, 6'b100000);
    #2 chk("tile0_out_delay38", 8'(cfg_out0), 8'(cb[37]));
    load_bits(ca, 4'b0100, 6'b100000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 6'b100000);
    #2 chk("tile0_oe", 8'(oe0), 8'b0101);
    chk("tile1_oe", 8'(oe1), 8'b1010);
    chk("tile1_pad1_ic5", 8'(to_io1[1]), 8'd1);
    chk("tile0_ic0_io2", 8'(to_ic0[0]), 8'd1);

    for (int it = 0; it < 300; it++) begin
      int op = int'($urandom_range(0, 9));
      if (it == 150) begin
        for (int k = 0; k < 10; k++) rand_cyc(1'b1, 1'b0);
        @(negedge clock);
        config_enable = 1'b0; config_commit = 1'b0; enable = 1'b0;
        data_from_io = 4'b1110; data_from_ic = 6'b111110;
        #2 nreset = 1'b0;
        #1;
        chk("rst_to_io0", 8'(to_io0), 8'd0);
        chk("rst_oe0", 8'(oe0), 8'd0);
        chk("rst_to_ic0", 8'(to_ic0), 8'd0);
        chk("rst_cfg_out0", 8'(cfg_out0), 8'd0);
        chk("rst_loaded1", 8'(loaded1), 8'd0);
        chk("rst_oe1", 8'(oe1), 8'd0);
        reset_model();
        check_all();
        @(negedge clock);
        nreset = 1'b1;
        rc = {6'($urandom), 32'($urandom)};
        load_bits(rc, 4'($urandom), 6'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'($urandom), 6'($urandom));
        for (int k = 0; k < 20; k++) rand_cyc(1'b0, 1'b0);
      end else if (op < 5) begin
        int n = int'($urandom_range(1, 45));
        for (int k = 0; k < n; k++) rand_cyc(1'b1, 1'($urandom_range(0, 3) == 0));
      end else if (op < 7) begin
        rand_cyc(1'b0, 1'b1);
      end else begin
        rand_cyc(1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
